// File: rtl/tagged_cr_file_pkg.sv
// Shared PowerPC CR types: field count/width defaults and the big-endian field type.
package ppc_types;
  localparam int CR_NUM_FIELDS  = 8;
  localparam int CR_FIELD_WIDTH = 4;
  typedef logic [0:3] cr_field_t;
endpackage

// File: rtl/tagged_cr_file_if.sv
// Result-bus / rename / read bundle of the tagged CR file. Masks and values are
// big-endian: field 0 is the leftmost bit/nibble.
interface tagged_cr_file_if #(
  parameter int RS_ID_WIDTH  = 5,
  parameter int NUM_FIELDS   = ppc_types::CR_NUM_FIELDS,
  parameter int FIELD_WIDTH  = ppc_types::CR_FIELD_WIDTH,
  parameter int NUM_WR_PORTS = 2
);
  localparam int BW = $clog2(NUM_FIELDS + 1);

  logic [0:NUM_FIELDS-1]                                read_value_valid;
  logic [0:NUM_FIELDS*FIELD_WIDTH-1]                    read_value;
  logic [0:NUM_FIELDS-1][RS_ID_WIDTH-1:0]               read_rs_id;
  logic [NUM_WR_PORTS-1:0][0:NUM_FIELDS-1]              write_enable;
  logic [NUM_WR_PORTS-1:0][0:NUM_FIELDS*FIELD_WIDTH-1]  write_value;
  logic [NUM_WR_PORTS-1:0][RS_ID_WIDTH-1:0]             write_rs_id;
  logic [0:NUM_FIELDS-1]                                update_enable;
  logic [RS_ID_WIDTH-1:0]                               update_rs_id;
  logic                                                 flush;
  logic [BW-1:0]                                        busy_count;

  modport master (
    output write_enable, write_value, write_rs_id, update_enable, update_rs_id, flush,
    input  read_value_valid, read_value, read_rs_id, busy_count
  );
  modport slave (
    input  write_enable, write_value, write_rs_id, update_enable, update_rs_id, flush,
    output read_value_valid, read_value, read_rs_id, busy_count
  );
endinterface

// File: rtl/tagged_cr_file_slot.sv
// One renamed CR field: tag match against the result ports, lowest port wins.
// CR_FILE_BYPASS_EN forwards the winning write to the read outputs in the same cycle.
module cr_field_slot #(
  parameter int RS_ID_WIDTH  = 5,
  parameter int FIELD_WIDTH  = 4,
  parameter int NUM_WR_PORTS = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_WR_PORTS-1:0]                   wr_en,
  input  logic [NUM_WR_PORTS-1:0][FIELD_WIDTH-1:0]  wr_val,
  input  logic [NUM_WR_PORTS-1:0][RS_ID_WIDTH-1:0]  wr_tag,
  input  logic                                      upd_en,
  input  logic [RS_ID_WIDTH-1:0]                    upd_tag,
  input  logic                                      flush,
  output logic                                      rd_valid,
  output logic [FIELD_WIDTH-1:0]                    rd_value,
  output logic [RS_ID_WIDTH-1:0]                    rd_tag,
  output logic                                      valid_nxt
);
  logic                   valid_q;
  logic [FIELD_WIDTH-1:0] value_q, value_nxt, hit_val;
  logic [RS_ID_WIDTH-1:0] tag_q, tag_nxt;
  logic                   hit;

  // Walk ports high to low so the lowest matching index overrides.
  always_comb begin
    hit     = 1'b0;
    hit_val = value_q;
    for (int p = NUM_WR_PORTS - 1; p >= 0; p--) begin
      if (wr_en[p] && !valid_q && (wr_tag[p] == tag_q)) begin
        hit     = 1'b1;
        hit_val = wr_val[p];
      end
    end
  end

  // A rename in the same cycle as a write keeps the data but reopens the field.
  always_comb begin
    valid_nxt = valid_q | hit;
    value_nxt = hit_val;
    tag_nxt   = tag_q;
    if (flush) begin
      valid_nxt = 1'b1;
    end else if (upd_en) begin
      valid_nxt = 1'b0;
      tag_nxt   = upd_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b1;
      value_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_nxt;
      value_q <= value_nxt;
      tag_q   <= tag_nxt;
    end
  end

  assign rd_tag = tag_q;
`ifdef CR_FILE_BYPASS_EN
  assign rd_valid = valid_q | hit;
  assign rd_value = hit_val;
`else
  assign rd_valid = valid_q;
  assign rd_value = value_q;
`endif
endmodule

// File: rtl/tagged_cr_file.sv
// Tagged (renamed) condition-register file: NUM_FIELDS slots plus a registered busy count.
// Optional same-cycle write bypass under CR_FILE_BYPASS_EN.
module tagged_cr_file
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH  = 5,
  parameter int NUM_FIELDS   = CR_NUM_FIELDS,
  parameter int FIELD_WIDTH  = CR_FIELD_WIDTH,
  parameter int NUM_WR_PORTS = 2
) (
  input logic              clk,
  input logic              rst,
  tagged_cr_file_if.slave  bus
);
  localparam int BW = $clog2(NUM_FIELDS + 1);

  logic [0:NUM_FIELDS-1] valid_nxt;
  logic [BW-1:0]         busy_nxt, busy_q;

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_slot
    logic [NUM_WR_PORTS-1:0]                  wr_en;
    logic [NUM_WR_PORTS-1:0][FIELD_WIDTH-1:0] wr_val;

    for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_port
      assign wr_en[p]  = bus.write_enable[p][f];
      assign wr_val[p] = bus.write_value[p][f*FIELD_WIDTH +: FIELD_WIDTH];
    end

    cr_field_slot #(
      .RS_ID_WIDTH (RS_ID_WIDTH),
      .FIELD_WIDTH (FIELD_WIDTH),
      .NUM_WR_PORTS(NUM_WR_PORTS)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_val   (wr_val),
      .wr_tag   (bus.write_rs_id),
      .upd_en   (bus.update_enable[f]),
      .upd_tag  (bus.update_rs_id),
      .flush    (bus.flush),
      .rd_valid (bus.read_value_valid[f]),
      .rd_value (bus.read_value[f*FIELD_WIDTH +: FIELD_WIDTH]),
      .rd_tag   (bus.read_rs_id[f]),
      .valid_nxt(valid_nxt[f])
    );
  end

  // Counted from next-state so the count lands on the same edge as the fields.
  always_comb begin
    busy_nxt = '0;
    for (int f = 0; f < NUM_FIELDS; f++) busy_nxt = busy_nxt + BW'(!valid_nxt[f]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign bus.busy_count = busy_q;
endmodule
